wb_commit_n: RTL and testbench

WB_COMMIT_N -- requirements
Module: wb_commit_n

---
 rtl/wb_commit_n_if.sv | 62 ++++++
 rtl/wb_commit_n.sv | 192 +++++++++++++++++++
 tb/tb_wb_commit_n.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_n_if.sv
// wb_commit_n_if: bundle of the writeback-commit stage signals.
//   master : memory-stage / CSR / downstream side (drives *_i, observes *_o)
//   slave  : the wb_commit_n stage itself
// Signals: per-lane valid/PC/GPR write/exception/kernel/badv inputs, downstream
// allow-in, privilege level; committed GPR writes, flush pulse, exception and
// ertn report, retire counter.
// With WB_COMMIT_TRACE_EN defined, debug_pc_o / debug_commit_o are added.
// LANES must match the LANES parameter of the attached wb_commit_n.
interface wb_commit_n_if #(
    parameter int unsigned LANES = 2
);
    logic [LANES-1:0]    mw_valid_i;
    logic                wb_allowin_o;
    logic                rfb_allowin_i;
    logic [LANES*32-1:0] mw_pc_i;
    logic [LANES-1:0]    mw_rf_we_i;
    logic [LANES*5-1:0]  mw_rf_waddr_i;
    logic [LANES*32-1:0] mw_rf_wdata_i;
    logic [LANES*17-1:0] mw_excep_type_i;
    logic [LANES-1:0]    mw_kernel_i;
    logic [LANES*32-1:0] mw_badv_i;
    logic [1:0]          cpu_level_i;

    logic [LANES-1:0]    rf_we_o;
    logic [LANES*5-1:0]  rf_waddr_o;
    logic [LANES*32-1:0] rf_wdata_o;
    logic                wb_flush_o;
    logic                excep_en_o;
    logic [5:0]          excep_ecode_o;
    logic [8:0]          excep_esubcode_o;
    logic [31:0]         excep_pc_o;
    logic                excep_badv_we_o;
    logic [31:0]         excep_badv_o;
    logic                ertn_en_o;
    logic [31:0]         retire_cnt_o;
`ifdef WB_COMMIT_TRACE_EN
    logic [LANES*32-1:0] debug_pc_o;
    logic [LANES-1:0]    debug_commit_o;
`endif

    modport master (
        output mw_valid_i, rfb_allowin_i, mw_pc_i, mw_rf_we_i, mw_rf_waddr_i, mw_rf_wdata_i,
               mw_excep_type_i, mw_kernel_i, mw_badv_i, cpu_level_i,
        input  wb_allowin_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_flush_o, excep_en_o,
               excep_ecode_o, excep_esubcode_o, excep_pc_o, excep_badv_we_o, excep_badv_o,
               ertn_en_o, retire_cnt_o
`ifdef WB_COMMIT_TRACE_EN
        , input debug_pc_o, debug_commit_o
`endif
    );

    modport slave (
        input  mw_valid_i, rfb_allowin_i, mw_pc_i, mw_rf_we_i, mw_rf_waddr_i, mw_rf_wdata_i,
               mw_excep_type_i, mw_kernel_i, mw_badv_i, cpu_level_i,
        output wb_allowin_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_flush_o, excep_en_o,
               excep_ecode_o, excep_esubcode_o, excep_pc_o, excep_badv_we_o, excep_badv_o,
               ertn_en_o, retire_cnt_o
`ifdef WB_COMMIT_TRACE_EN
        , output debug_pc_o, debug_commit_o
`endif
    );
endinterface

// File: rtl/wb_commit_n.sv
// wb_commit_n: multi-lane writeback / commit stage with precise exceptions.
// Holds one bundle (per-lane valid + fields). On a commit cycle the oldest
// trapping lane k is found; lanes below k commit their GPR writes, lane k and
// younger are squashed, lane k's exception or ertn is reported and a one-cycle
// flush is raised, after which FLUSH_CYCLES bubble cycles drop the held bundle.
// Ports: clk, rst_n (async active-low), bus (wb_commit_n_if.slave).
// Optional: define WB_COMMIT_TRACE_EN for debug_pc_o / debug_commit_o.
module wb_commit_n #(
    parameter int unsigned LANES        = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic          clk,
    input logic          rst_n,
    wb_commit_n_if.slave bus
);
    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic [LANES-1:0]        valid_q, we_q, kernel_q;
    logic [LANES-1:0][4:0]   waddr_q;
    logic [LANES-1:0][31:0]  pc_q, wdata_q, badv_q;
    logic [LANES-1:0][16:0]  etype_q;

    logic held_any, commit, flush;
    assign held_any = |valid_q;
    assign commit   = (state_q == StRun) && held_any && bus.rfb_allowin_i;
    assign bus.wb_allowin_o = (state_q == StRun) && (!held_any || bus.rfb_allowin_i);

    // Lane scan: oldest trapping lane blocks itself and everything younger.
    logic [LANES-1:0] we_mask, retire_mask;
    logic [15:0] lane_vec, sel_vec;
    logic        sel_ertn, blocked;
    logic [31:0] sel_pc, sel_badv;
    always_comb begin
        we_mask     = '0;
        retire_mask = '0;
        lane_vec    = '0;
        sel_vec     = '0;
        sel_ertn    = 1'b0;
        sel_pc      = '0;
        sel_badv    = '0;
        blocked     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_vec = etype_q[i][15:0];
            // Privileged op in user mode occupies the IPE slot (bit 12).
            if (kernel_q[i] && bus.cpu_level_i == 2'b11) lane_vec[12] = 1'b1;
            if (valid_q[i] && !blocked) begin
                if (lane_vec != '0 || etype_q[i][16]) begin
                    blocked  = 1'b1;
                    sel_vec  = lane_vec;
                    sel_ertn = etype_q[i][16];
                    sel_pc   = pc_q[i];
                    sel_badv = badv_q[i];
                    // An ertn lane retires but never writes the GPR file.
                    if (lane_vec == '0) retire_mask[i] = 1'b1;
                end else begin
                    retire_mask[i] = 1'b1;
                    we_mask[i]     = we_q[i];
                end
            end
        end
    end

    // Exception decode: lowest set bit wins.
    logic [3:0] exc_idx;
    logic [5:0] ecode;
    logic       excep_en, ertn_en;
    always_comb begin
        exc_idx = '0;
        for (int b = 15; b >= 0; b--) begin
            if (sel_vec[b]) exc_idx = 4'(b);
        end
        case (exc_idx)
            4'd0:    ecode = 6'h00;
            4'd1:    ecode = 6'h01;
            4'd2:    ecode = 6'h02;
            4'd3:    ecode = 6'h03;
            4'd4:    ecode = 6'h04;
            4'd5:    ecode = 6'h07;
            4'd6:    ecode = 6'h08;
            4'd7:    ecode = 6'h08;
            4'd8:    ecode = 6'h09;
            4'd9:    ecode = 6'h0B;
            4'd10:   ecode = 6'h0C;
            4'd11:   ecode = 6'h0D;
            4'd12:   ecode = 6'h0E;
            4'd13:   ecode = 6'h0F;
            4'd14:   ecode = 6'h12;
            default: ecode = 6'h3F;
        endcase
        excep_en = commit && (sel_vec != '0);
        ertn_en  = commit && sel_ertn && (sel_vec == '0);
        flush    = excep_en || ertn_en;
    end

    assign bus.excep_en_o       = excep_en;
    assign bus.ertn_en_o        = ertn_en;
    assign bus.wb_flush_o       = flush;
    assign bus.excep_ecode_o    = excep_en ? ecode : 6'h00;
    assign bus.excep_esubcode_o = (excep_en && exc_idx == 4'd7) ? 9'd1 : 9'd0;
    assign bus.excep_pc_o       = flush ? sel_pc : 32'h0;
    assign bus.excep_badv_we_o  = excep_en && (exc_idx == 4'd6 || exc_idx == 4'd8);
    assign bus.excep_badv_o     = !bus.excep_badv_we_o ? 32'h0 :
                                  (exc_idx == 4'd6) ? sel_pc : sel_badv;
    assign bus.retire_cnt_o     = retire_cnt_q;

    logic [LANES-1:0]       rf_we;
    logic [LANES-1:0][4:0]  rf_waddr;
    logic [LANES-1:0][31:0] rf_wdata;
    logic [2:0]             n_retire;
    always_comb begin
        n_retire = '0;
        for (int i = 0; i < LANES; i++) begin
            rf_we[i]    = commit && we_mask[i];
            rf_waddr[i] = rf_we[i] ? waddr_q[i] : 5'd0;
            rf_wdata[i] = rf_we[i] ? wdata_q[i] : 32'd0;
            n_retire    = n_retire + 3'(retire_mask[i]);
        end
        retire_cnt_d = commit ? retire_cnt_q + 32'(n_retire) : retire_cnt_q;
    end
    assign bus.rf_we_o    = rf_we;
    assign bus.rf_waddr_o = rf_waddr;
    assign bus.rf_wdata_o = rf_wdata;

`ifdef WB_COMMIT_TRACE_EN
    logic [LANES-1:0][31:0] dbg_pc;
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            dbg_pc[i] = (commit && retire_mask[i]) ? pc_q[i] : 32'd0;
        end
    end
    assign bus.debug_pc_o     = dbg_pc;
    assign bus.debug_commit_o = commit ? retire_mask : '0;
`endif

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StRun: begin
                if (flush) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                if (flush_cnt_q == 3'(FLUSH_CYCLES - 1)) begin
                    state_d     = StRun;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
            valid_q      <= '0;
            we_q         <= '0;
            kernel_q     <= '0;
            waddr_q      <= '0;
            pc_q         <= '0;
            wdata_q      <= '0;
            badv_q       <= '0;
            etype_q      <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            if (state_q == StFlush) begin
                valid_q <= '0;
            end else if (bus.wb_allowin_o) begin
                valid_q  <= bus.mw_valid_i;
                we_q     <= bus.mw_rf_we_i;
                kernel_q <= bus.mw_kernel_i;
                waddr_q  <= bus.mw_rf_waddr_i;
                pc_q     <= bus.mw_pc_i;
                wdata_q  <= bus.mw_rf_wdata_i;
                badv_q   <= bus.mw_badv_i;
                etype_q  <= bus.mw_excep_type_i;
            end
        end
    end
endmodule

// File: tb/tb_wb_commit_n.sv
module tb_wb_commit_n;
    localparam int unsigned LANES = 2;
    localparam int unsigned FC    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_commit_n_if #(.LANES(LANES)) bus ();
    wb_commit_n #(.LANES(LANES), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [1:0]  rf_we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic        en;
        logic [5:0]  ecode;
        logic [8:0]  sub;
        logic [31:0] pc;
        logic        badv_we;
        logic [31:0] badv;
        logic        ertn;
        logic        flush;
        logic [31:0] retire;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_retire = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.mw_valid_i = '0; bus.rfb_allowin_i = 1'b1; bus.mw_pc_i = '0;
        bus.mw_rf_we_i = '0; bus.mw_rf_waddr_i = '0; bus.mw_rf_wdata_i = '0;
        bus.mw_excep_type_i = '0; bus.mw_kernel_i = '0; bus.mw_badv_i = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd,
                            input logic [16:0] et, input logic kern, input logic [31:0] bv);
        bus.mw_valid_i[l]              = 1'b1;
        bus.mw_pc_i[l*32 +: 32]        = pc;
        bus.mw_rf_we_i[l]              = we;
        bus.mw_rf_waddr_i[l*5 +: 5]    = wa;
        bus.mw_rf_wdata_i[l*32 +: 32]  = wd;
        bus.mw_excep_type_i[l*17 +: 17] = et;
        bus.mw_kernel_i[l]             = kern;
        bus.mw_badv_i[l*32 +: 32]      = bv;
    endtask

    task automatic push(input logic [1:0] we, input logic [9:0] wa, input logic [63:0] wd,
                        input logic en, input logic [5:0] ec, input logic [8:0] sub,
                        input logic [31:0] pc, input logic bwe, input logic [31:0] bv,
                        input logic ertn, input logic [2:0] nret);
        exp_t e;
        exp_retire = exp_retire + 32'(nret);
        e = '{rf_we: we, waddr: wa, wdata: wd, en: en, ecode: ec, sub: sub, pc: pc,
              badv_we: bwe, badv: bv, ertn: ertn, flush: en | ertn, retire: exp_retire};
        sb.push_back(e);
    endtask

    // Capture the driven bundle; optionally stall downstream; end on the commit negedge.
    task automatic launch(input int stall);
        check("allowin_pre", 64'(bus.wb_allowin_o), 64'd1);
        @(posedge clk);
        #1;
        bus.mw_valid_i = '0;
        if (stall > 0) bus.rfb_allowin_i = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_rf_we", 64'(bus.rf_we_o), 64'd0);
            check("stall_excep", 64'({bus.excep_en_o, bus.ertn_en_o, bus.wb_flush_o}), 64'd0);
            check("stall_allowin", 64'(bus.wb_allowin_o), 64'd0);
        end
        if (stall > 0) begin
            bus.rfb_allowin_i = 1'b1;
            #1;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic check_commit();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check("rf_we", 64'(bus.rf_we_o), 64'(e.rf_we));
        check("rf_waddr", 64'(bus.rf_waddr_o), 64'(e.waddr));
        check("rf_wdata", 64'(bus.rf_wdata_o), e.wdata);
        check("excep_en", 64'(bus.excep_en_o), 64'(e.en));
        check("ecode", 64'(bus.excep_ecode_o), 64'(e.ecode));
        check("esubcode", 64'(bus.excep_esubcode_o), 64'(e.sub));
        check("excep_pc", 64'(bus.excep_pc_o), 64'(e.pc));
        check("badv_we", 64'(bus.excep_badv_we_o), 64'(e.badv_we));
        check("badv", 64'(bus.excep_badv_o), 64'(e.badv));
        check("ertn", 64'(bus.ertn_en_o), 64'(e.ertn));
        check("flush", 64'(bus.wb_flush_o), 64'(e.flush));
        @(negedge clk);
        check("retire", 64'(bus.retire_cnt_o), 64'(e.retire));
        check("flush_once", 64'(bus.wb_flush_o), 64'd0);
        if (e.flush) begin
            for (int c = 0; c < int'(FC); c++) begin
                if (c > 0) @(negedge clk);
                check("flush_allowin", 64'(bus.wb_allowin_o), 64'd0);
            end
            @(negedge clk);
        end
        check("allowin_post", 64'(bus.wb_allowin_o), 64'd1);
    endtask

    initial begin
        clear_inputs();
        bus.cpu_level_i = 2'b00;
        @(negedge clk);
        check("rst_allowin", 64'(bus.wb_allowin_o), 64'd1);
        check("rst_rf_we", 64'(bus.rf_we_o), 64'd0);
        check("rst_flush", 64'(bus.wb_flush_o), 64'd0);
        check("rst_retire", 64'(bus.retire_cnt_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both lanes clean.
        set_lane(0, 32'h1000, 1'b1, 5'd5, 32'h1111_1111, 17'h0, 1'b0, 32'h0);
        set_lane(1, 32'h1004, 1'b1, 5'd6, 32'h2222_2222, 17'h0, 1'b0, 32'h0);
        push(2'b11, {5'd6, 5'd5}, {32'h2222_2222, 32'h1111_1111}, 1'b0, 6'h0, 9'd0,
             32'h0, 1'b0, 32'h0, 1'b0, 3'd2);
        launch(0); check_commit();

        // Lane1 SYS, lane0 clean.
        clear_inputs();
        set_lane(0, 32'h2000, 1'b1, 5'd7, 32'h77, 17'h0, 1'b0, 32'h0);
        set_lane(1, 32'h2004, 1'b1, 5'd8, 32'h88, 17'h00200, 1'b0, 32'h0);
        push(2'b01, {5'd0, 5'd7}, {32'h0, 32'h77}, 1'b1, 6'h0B, 9'd0,
             32'h2004, 1'b0, 32'h0, 1'b0, 3'd1);
        launch(0); check_commit();

        // Lane0 ALE, lane1 INE.
        clear_inputs();
        set_lane(0, 32'h3000, 1'b1, 5'd9, 32'h99, 17'h00100, 1'b0, 32'h1003);
        set_lane(1, 32'h3004, 1'b1, 5'd10, 32'haa, 17'h00800, 1'b0, 32'h0);
        push(2'b00, 10'd0, 64'd0, 1'b1, 6'h09, 9'd0, 32'h3000, 1'b1, 32'h1003, 1'b0, 3'd0);
        launch(0); check_commit();

        // User-mode kernel op in lane0, with a 3-cycle downstream stall.
        clear_inputs();
        bus.cpu_level_i = 2'b11;
        set_lane(0, 32'h4000, 1'b1, 5'd3, 32'h33, 17'h0, 1'b1, 32'h0);
        set_lane(1, 32'h4004, 1'b1, 5'd4, 32'h44, 17'h0, 1'b0, 32'h0);
        push(2'b00, 10'd0, 64'd0, 1'b1, 6'h0E, 9'd0, 32'h4000, 1'b0, 32'h0, 1'b0, 3'd0);
        launch(3); check_commit();
        bus.cpu_level_i = 2'b00;

        // Ertn in lane0: retires, no GPR write, lane1 squashed.
        clear_inputs();
        set_lane(0, 32'h5000, 1'b1, 5'd4, 32'h55, 17'h10000, 1'b0, 32'h0);
        set_lane(1, 32'h5004, 1'b1, 5'd5, 32'h56, 17'h0, 1'b0, 32'h0);
        push(2'b00, 10'd0, 64'd0, 1'b0, 6'h0, 9'd0, 32'h5000, 1'b0, 32'h0, 1'b1, 3'd1);
        launch(0); check_commit();

        // ADEF in lane1: badv takes the PC.
        clear_inputs();
        set_lane(0, 32'h6000, 1'b0, 5'd1, 32'h61, 17'h0, 1'b0, 32'h0);
        set_lane(1, 32'h6004, 1'b1, 5'd2, 32'h62, 17'h00040, 1'b0, 32'hdead);
        push(2'b00, 10'd0, 64'd0, 1'b1, 6'h08, 9'd0, 32'h6004, 1'b1, 32'h6004, 1'b0, 3'd1);
        launch(0); check_commit();

        // Counter wrap.
        clear_inputs();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.retire_cnt_q;
        @(negedge clk);
        check("preload", 64'(bus.retire_cnt_o), 64'hFFFF_FFFF);
        exp_retire = 32'hFFFF_FFFF;
        set_lane(0, 32'h7000, 1'b1, 5'd1, 32'ha, 17'h0, 1'b0, 32'h0);
        set_lane(1, 32'h7004, 1'b1, 5'd2, 32'hb, 17'h0, 1'b0, 32'h0);
        push(2'b11, {5'd2, 5'd1}, {32'hb, 32'ha}, 1'b0, 6'h0, 9'd0,
             32'h0, 1'b0, 32'h0, 1'b0, 3'd2);
        launch(0); check_commit();

        // Reset while a bundle is stalled: it must vanish.
        clear_inputs();
        set_lane(0, 32'h8000, 1'b1, 5'd1, 32'h1, 17'h0, 1'b0, 32'h0);
        set_lane(1, 32'h8004, 1'b1, 5'd2, 32'h2, 17'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        bus.mw_valid_i = '0;
        bus.rfb_allowin_i = 1'b0;
        @(negedge clk);
        check("stall_hold", 64'(bus.wb_allowin_o), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_allowin", 64'(bus.wb_allowin_o), 64'd1);
        check("mid_rst_retire", 64'(bus.retire_cnt_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rfb_allowin_i = 1'b1;
        #1;
        check("post_rst_rf_we", 64'(bus.rf_we_o), 64'd0);
        check("post_rst_flush", 64'(bus.wb_flush_o), 64'd0);
        @(negedge clk);
        check("post_rst_retire", 64'(bus.retire_cnt_o), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
